// File: rtl/sensor_cmd_scheduler.sv
// Command/response sequencer between the UART byte stream and the shared DHT11 reader.
// Handles one-shot host requests and periodic continuous temperature/humidity reads.
module sensor_cmd_scheduler #(
  parameter int ADDR_W        = 5,
  parameter int NUM_SENSORS   = 32,
  parameter int PERIOD_CYCLES = 50_000_000,
  parameter int BYTE_TIMEOUT  = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              sens_start,
  output logic [ADDR_W-1:0] sens_addr,
  input  logic              sens_done,
  input  logic              sens_err,
  input  logic [7:0]        sens_temp,
  input  logic [7:0]        sens_hum,
  output logic              tx_start,
  output logic [7:0]        tx_code,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              cont_temp_on,
  output logic              cont_hum_on,
  output logic              cmd_drop,
  output logic              busy
);

  localparam int PCW = $clog2(PERIOD_CYCLES + 1);
  localparam int TCW = $clog2(BYTE_TIMEOUT + 1);
  localparam logic [PCW-1:0] PERIOD_LAST  = PCW'(PERIOD_CYCLES - 1);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(BYTE_TIMEOUT - 1);
  localparam logic [8:0]     NUM_SENS_W   = 9'(NUM_SENSORS);

  typedef enum logic [2:0] {IDLE, DECODE, ISSUE, WAIT_SENS, SEND, SEND_HOLD} state_t;

  state_t             state_r, state_n;
  logic               have_cmd_r;
  logic [7:0]         rx_cmd_r;
  logic [TCW-1:0]     to_cnt_r;
  logic               slot_full_r;
  logic [7:0]         slot_cmd_r, slot_addr_r;
  logic [PCW-1:0]     per_cnt_r;
  logic               tick_pending_r;
  logic               alt_r;
  logic [7:0]         cur_cmd_r, cur_addr_r;
  logic [ADDR_W-1:0]  issue_addr_r, temp_addr_r, hum_addr_r;
  logic [7:0]         resp_code_r, resp_data_r;
  logic               hold_first_r;
  logic               expired_s, pair_done_s, consume_s, service_s, tick_hum_s;
  logic               cmd_invalid_s, cmd_off_s, addr_invalid_s;

  // Pair completion, half-pair expiry and decode classification
  always_comb begin
    expired_s      = have_cmd_r && (to_cnt_r == TIMEOUT_LAST);
    pair_done_s    = rx_valid && have_cmd_r && !expired_s;
    cmd_invalid_s  = (cur_cmd_r > 8'h06);
    cmd_off_s      = (cur_cmd_r == 8'h05) || (cur_cmd_r == 8'h06);
    addr_invalid_s = ({1'b0, cur_addr_r} >= NUM_SENS_W);
    if (cont_temp_on && cont_hum_on) begin
      tick_hum_s = alt_r;
    end else begin
      tick_hum_s = cont_hum_on;
    end
  end

  // Next-state logic; the pending slot wins over a periodic tick
  always_comb begin
    state_n   = state_r;
    consume_s = 1'b0;
    service_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (slot_full_r) begin
          state_n   = DECODE;
          consume_s = 1'b1;
        end else if (tick_pending_r) begin
          state_n   = ISSUE;
          service_s = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      DECODE: begin
        if (cmd_invalid_s || cmd_off_s || addr_invalid_s) begin
          state_n = SEND;
        end else begin
          state_n = ISSUE;
        end
      end
      ISSUE:     state_n = WAIT_SENS;
      WAIT_SENS: state_n = sens_done ? SEND : WAIT_SENS;
      SEND:      state_n = tx_busy ? SEND : SEND_HOLD;
      SEND_HOLD: state_n = (!hold_first_r && !tx_busy) ? IDLE : SEND_HOLD;
      default:   state_n = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_n;
  end

  // Byte pair assembler with timeout and one-entry pending slot
  always_ff @(posedge clk) begin
    if (reset) begin
      have_cmd_r  <= 1'b0;
      rx_cmd_r    <= 8'h00;
      to_cnt_r    <= '0;
      slot_full_r <= 1'b0;
      slot_cmd_r  <= 8'h00;
      slot_addr_r <= 8'h00;
      cmd_drop    <= 1'b0;
    end else begin
      cmd_drop <= pair_done_s && slot_full_r;
      if (rx_valid) begin
        to_cnt_r <= '0;
        if (pair_done_s) begin
          have_cmd_r <= 1'b0;
        end else begin
          have_cmd_r <= 1'b1;
          rx_cmd_r   <= rx_data;
        end
      end else if (expired_s) begin
        have_cmd_r <= 1'b0;
        to_cnt_r   <= '0;
      end else if (have_cmd_r) begin
        to_cnt_r <= to_cnt_r + TCW'(1);
      end
      if (pair_done_s && !slot_full_r) begin
        slot_full_r <= 1'b1;
        slot_cmd_r  <= rx_cmd_r;
        slot_addr_r <= rx_data;
      end else if (consume_s) begin
        slot_full_r <= 1'b0;
      end
    end
  end

  // Period counter; a wrap raises tick_pending, which wins over a same-cycle service
  always_ff @(posedge clk) begin
    if (reset || !(cont_temp_on || cont_hum_on)) begin
      per_cnt_r      <= '0;
      tick_pending_r <= 1'b0;
    end else if (per_cnt_r == PERIOD_LAST) begin
      per_cnt_r      <= '0;
      tick_pending_r <= 1'b1;
    end else begin
      per_cnt_r <= per_cnt_r + PCW'(1);
      if (service_s) tick_pending_r <= 1'b0;
    end
  end

  // Transaction datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_cmd_r    <= 8'h00;
      cur_addr_r   <= 8'h00;
      issue_addr_r <= '0;
      temp_addr_r  <= '0;
      hum_addr_r   <= '0;
      resp_code_r  <= 8'h00;
      resp_data_r  <= 8'h00;
      alt_r        <= 1'b0;
      hold_first_r <= 1'b0;
      sens_start   <= 1'b0;
      sens_addr    <= '0;
      tx_start     <= 1'b0;
      tx_code      <= 8'h00;
      tx_data      <= 8'h00;
      cont_temp_on <= 1'b0;
      cont_hum_on  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sens_start   <= 1'b0;
      tx_start     <= 1'b0;
      hold_first_r <= 1'b0;
      busy         <= (state_n != IDLE);
      case (state_r)
        IDLE: begin
          if (consume_s) begin
            cur_cmd_r  <= slot_cmd_r;
            cur_addr_r <= slot_addr_r;
          end else if (service_s) begin
            cur_cmd_r    <= tick_hum_s ? 8'h04 : 8'h03;
            issue_addr_r <= tick_hum_s ? hum_addr_r : temp_addr_r;
            if (cont_temp_on && cont_hum_on) alt_r <= ~alt_r;
          end
        end
        DECODE: begin
          issue_addr_r <= cur_addr_r[ADDR_W-1:0];
          if (cmd_invalid_s) begin
            resp_code_r <= 8'hFF;
            resp_data_r <= cur_cmd_r;
          end else if (cur_cmd_r == 8'h05) begin
            cont_temp_on <= 1'b0;
            resp_code_r  <= 8'h0A;
            resp_data_r  <= 8'h00;
          end else if (cur_cmd_r == 8'h06) begin
            cont_hum_on <= 1'b0;
            resp_code_r <= 8'h0B;
            resp_data_r <= 8'h00;
          end else if (addr_invalid_s) begin
            resp_code_r <= 8'hFE;
            resp_data_r <= cur_addr_r;
          end else if (cur_cmd_r == 8'h03) begin
            cont_temp_on <= 1'b1;
            temp_addr_r  <= cur_addr_r[ADDR_W-1:0];
          end else if (cur_cmd_r == 8'h04) begin
            cont_hum_on <= 1'b1;
            hum_addr_r  <= cur_addr_r[ADDR_W-1:0];
          end
        end
        ISSUE: begin
          sens_start <= 1'b1;
          sens_addr  <= issue_addr_r;
        end
        WAIT_SENS: begin
          if (sens_done) begin
            if (sens_err) begin
              resp_code_r <= 8'h1F;
              resp_data_r <= 8'(sens_addr);
            end else begin
              case (cur_cmd_r)
                8'h00:   begin resp_code_r <= 8'h08; resp_data_r <= sens_hum;  end
                8'h01:   begin resp_code_r <= 8'h07; resp_data_r <= 8'h00;     end
                8'h02:   begin resp_code_r <= 8'h09; resp_data_r <= sens_temp; end
                8'h03:   begin resp_code_r <= 8'h0D; resp_data_r <= sens_temp; end
                8'h04:   begin resp_code_r <= 8'h0E; resp_data_r <= sens_hum;  end
                default: begin resp_code_r <= 8'hFF; resp_data_r <= cur_cmd_r; end
              endcase
            end
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_start     <= 1'b1;
            tx_code      <= resp_code_r;
            tx_data      <= resp_data_r;
            hold_first_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_cmd_scheduler.sv
// Randomized self-checking bench for sensor_cmd_scheduler with a transaction-level
// response model, a behavioural DHT11 responder and a UART transmitter responder.
module tb_sensor_cmd_scheduler;
  localparam int PERIOD = 100;
  localparam int BT     = 40;

  logic       clk = 1'b0;
  logic       reset, rx_valid, sens_done, sens_err, tx_busy;
  logic [7:0] rx_data, sens_temp, sens_hum;
  logic       sens_start, tx_start, cont_temp_on, cont_hum_on, cmd_drop, busy;
  logic [4:0] sens_addr;
  logic [7:0] tx_code, tx_data;

  int tests_run = 0, tests_failed = 0;
  int cyc = 0, drop_cnt = 0, sens_lat_cfg = 0, err_cfg = 0;
  logic [7:0] txc_q[$], txd_q[$], rt_q[$], rh_q[$];
  logic       re_q[$];
  int         sa_q[$], st_q[$];

  sensor_cmd_scheduler #(.ADDR_W(5), .NUM_SENSORS(32), .PERIOD_CYCLES(PERIOD), .BYTE_TIMEOUT(BT)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .sens_start(sens_start), .sens_addr(sens_addr), .sens_done(sens_done), .sens_err(sens_err),
    .sens_temp(sens_temp), .sens_hum(sens_hum), .tx_start(tx_start), .tx_code(tx_code),
    .tx_data(tx_data), .tx_busy(tx_busy), .cont_temp_on(cont_temp_on), .cont_hum_on(cont_hum_on),
    .cmd_drop(cmd_drop), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Event monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (sens_start) begin sa_q.push_back(int'(sens_addr)); st_q.push_back(cyc); end
    if (tx_start) begin txc_q.push_back(tx_code); txd_q.push_back(tx_data); end
    if (cmd_drop) drop_cnt++;
  end

  // DHT11 responder: one read at a time, random data
  initial begin
    int lat;
    sens_done = 1'b0; sens_err = 1'b0; sens_temp = 8'h00; sens_hum = 8'h00;
    forever begin
      @(negedge clk);
      if (sens_start) begin
        lat = (sens_lat_cfg > 0) ? sens_lat_cfg : int'($urandom_range(3, 10));
        repeat (lat) @(negedge clk);
        sens_done = 1'b1;
        sens_err  = (err_cfg == 1) || (err_cfg == 2 && $urandom_range(0, 3) == 0);
        sens_temp = 8'($urandom_range(0, 255));
        sens_hum  = 8'($urandom_range(0, 255));
        rt_q.push_back(sens_temp); rh_q.push_back(sens_hum); re_q.push_back(sens_err);
        @(negedge clk);
        sens_done = 1'b0;
      end
    end
  end

  // UART transmitter responder: busy from the cycle after tx_start
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        @(negedge clk);
        tx_busy = 1'b1;
        repeat ($urandom_range(2, 6)) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] txc_at(int i); return (i < txc_q.size()) ? txc_q[i] : 8'h00; endfunction
  function automatic logic [7:0] txd_at(int i); return (i < txd_q.size()) ? txd_q[i] : 8'h00; endfunction
  function automatic logic [7:0] rt_at(int i);  return (i < rt_q.size())  ? rt_q[i]  : 8'h00; endfunction
  function automatic logic [7:0] rh_at(int i);  return (i < rh_q.size())  ? rh_q[i]  : 8'h00; endfunction
  function automatic logic       re_at(int i);  return (i < re_q.size())  ? re_q[i]  : 1'b0;  endfunction
  function automatic int         sa_at(int i);  return (i < sa_q.size())  ? sa_q[i]  : -1;    endfunction
  function automatic int         st_at(int i);  return (i < st_q.size())  ? st_q[i]  : 0;     endfunction

  // Expected response of a host command given the sensor's answer
  function automatic void ref_resp(input logic [7:0] cmd, input logic [7:0] addr, input logic err,
                                   input logic [7:0] t, input logic [7:0] h,
                                   output logic [7:0] code, output logic [7:0] data, output logic launch);
    launch = 1'b0; code = 8'hFF; data = cmd;
    if (cmd > 8'd6) begin code = 8'hFF; data = cmd; end
    else if (cmd == 8'd5) begin code = 8'h0A; data = 8'h00; end
    else if (cmd == 8'd6) begin code = 8'h0B; data = 8'h00; end
    else if (addr >= 8'd32) begin code = 8'hFE; data = addr; end
    else begin
      launch = 1'b1;
      if (err) begin code = 8'h1F; data = addr; end
      else begin
        case (cmd)
          8'd0:    begin code = 8'h08; data = h;     end
          8'd1:    begin code = 8'h07; data = 8'h00; end
          8'd2:    begin code = 8'h09; data = t;     end
          8'd3:    begin code = 8'h0D; data = t;     end
          default: begin code = 8'h0E; data = h;     end
        endcase
      end
    end
  endfunction

  task automatic clear_q();
    txc_q.delete(); txd_q.delete(); sa_q.delete(); st_q.delete();
    rt_q.delete(); rh_q.delete(); re_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk); rx_valid = 1'b1; rx_data = b;
    @(negedge clk); rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int i = 0;
    while (txc_q.size() < n && i < budget) begin @(negedge clk); i++; end
    check_eq(tag, 32'(txc_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 300) begin @(negedge clk); i++; end
    check_eq("idle", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_code(input logic [7:0] code, input string tag, output int idx);
    idx = -1;
    for (int i = 0; i < 600 && idx < 0; i++) begin
      @(negedge clk);
      foreach (txc_q[j]) if (idx < 0 && txc_q[j] == code) idx = j;
    end
    check_eq(tag, 32'(idx >= 0), 32'd1);
  endtask

  task automatic do_oneshot(input logic [7:0] cmd, input logic [7:0] addr);
    logic [7:0] ec, ed;
    logic       el;
    clear_q();
    send_byte(cmd); send_byte(addr);
    wait_tx(1, 400, "tx_wait");
    ref_resp(cmd, addr, re_at(0), rt_at(0), rh_at(0), ec, ed, el);
    check_eq("tx_code", txc_at(0), ec);
    check_eq("tx_data", txd_at(0), ed);
    check_eq("launches", sa_q.size(), 32'(el));
    if (el) check_eq("sens_addr", sa_at(0), 32'(addr));
    wait_idle();
  endtask

  initial begin
    int base, idx;
    logic [7:0] cmd, addr;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("rst_outs", {sens_start, sens_addr, tx_start, tx_code, tx_data, cmd_drop}, 32'd0);
    check_eq("rst_flags", {cont_temp_on, cont_hum_on, busy}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed one-shot commands and boundaries
    do_oneshot(8'h02, 8'h03);
    do_oneshot(8'h07, 8'h00);
    do_oneshot(8'h01, 8'h20);
    do_oneshot(8'h00, 8'h1F);
    err_cfg = 1; do_oneshot(8'h01, 8'h05); err_cfg = 0;
    do_oneshot(8'h05, 8'h40);

    // Half-pair timeout
    clear_q();
    send_byte(8'h02);
    repeat (BT + 10) @(negedge clk);
    check_eq("timeout_silent", txc_q.size() + sa_q.size(), 32'd0);
    do_oneshot(8'h02, 8'h03);

    // Pending slot and drop while a read is in flight
    clear_q(); base = drop_cnt; sens_lat_cfg = 50;
    send_byte(8'h02); send_byte(8'h03);
    repeat (6) @(negedge clk);
    send_byte(8'h01); send_byte(8'h04);
    send_byte(8'h00); send_byte(8'h05);
    sens_lat_cfg = 0;
    wait_tx(2, 400, "drop_tx_wait");
    repeat (150) @(negedge clk);
    check_eq("drop_pulses", drop_cnt - base, 32'd1);
    check_eq("drop_tx_count", txc_q.size(), 32'd2);
    check_eq("drop_first_code", txc_at(0), 32'h09);
    check_eq("drop_first_data", txd_at(0), rt_at(0));
    check_eq("drop_pend_code", txc_at(1), 32'h07);
    check_eq("drop_pend_addr", sa_at(1), 32'd4);

    // Randomized one-shot traffic
    err_cfg = 2;
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    cmd = 8'h00;
        2, 3:    cmd = 8'h01;
        4, 5:    cmd = 8'h02;
        6:       cmd = 8'h05;
        7:       cmd = 8'h06;
        default: cmd = 8'($urandom_range(7, 255));
      endcase
      addr = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
      do_oneshot(cmd, addr);
    end
    err_cfg = 0;

    // Continuous mode: immediate reads, then alternating ticks every PERIOD
    do_oneshot(8'h03, 8'h01);
    check_eq("cont_temp_set", 32'(cont_temp_on), 32'd1);
    do_oneshot(8'h04, 8'h02);
    check_eq("cont_hum_set", 32'(cont_hum_on), 32'd1);
    clear_q();
    wait_tx(4, 800, "tick_wait");
    for (int i = 0; i < 4; i++) begin
      check_eq("tick_addr", sa_at(i), (i % 2 == 0) ? 32'd1 : 32'd2);
      check_eq("tick_code", txc_at(i), (i % 2 == 0) ? 32'h0D : 32'h0E);
      check_eq("tick_data", txd_at(i), (i % 2 == 0) ? rt_at(i) : rh_at(i));
      if (i > 0) check_eq("tick_gap", st_at(i) - st_at(i - 1), 32'(PERIOD));
    end

    // Pending host pair is served before a tick that wrapped during a long read
    repeat (20) @(negedge clk);
    clear_q(); sens_lat_cfg = 130;
    for (int i = 0; i < 300 && sa_q.size() == 0; i++) @(negedge clk);
    send_byte(8'h01); send_byte(8'h07);
    sens_lat_cfg = 0;
    wait_tx(3, 700, "prio_wait");
    check_eq("prio_code0", txc_at(0), 32'h0D);
    check_eq("prio_code1", txc_at(1), 32'h07);
    check_eq("prio_addr1", sa_at(1), 32'd7);
    check_eq("prio_code2", txc_at(2), 32'h0E);
    check_eq("prio_addr2", sa_at(2), 32'd2);

    // Temperature off: only humidity ticks remain
    clear_q();
    send_byte(8'h05); send_byte(8'h00);
    wait_code(8'h0A, "temp_off_seen", idx);
    check_eq("temp_off_data", txd_at(idx), 32'h00);
    check_eq("temp_off_flag", 32'(cont_temp_on), 32'd0);
    clear_q();
    wait_tx(2, 500, "hum_only_wait");
    for (int i = 0; i < 2; i++) begin
      check_eq("hum_only_code", txc_at(i), 32'h0E);
      check_eq("hum_only_addr", sa_at(i), 32'd2);
      check_eq("hum_only_data", txd_at(i), rh_at(i));
    end
    clear_q();
    send_byte(8'h06); send_byte(8'h00);
    wait_code(8'h0B, "hum_off_seen", idx);
    check_eq("flags_off", {cont_temp_on, cont_hum_on}, 32'd0);
    wait_idle();
    clear_q();
    repeat (250) @(negedge clk);
    check_eq("no_ticks_after_off", txc_q.size() + sa_q.size(), 32'd0);

    // Reset during WAIT_SENS with a continuous flag set
    do_oneshot(8'h04, 8'h09);
    clear_q(); sens_lat_cfg = 40;
    send_byte(8'h02); send_byte(8'h06);
    for (int i = 0; i < 100 && sa_q.size() == 0; i++) @(negedge clk);
    check_eq("rst_read_addr", sa_at(0), 32'd6);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midrst_outs", {sens_start, sens_addr, tx_start, tx_code, tx_data, cmd_drop}, 32'd0);
    check_eq("midrst_flags", {cont_temp_on, cont_hum_on, busy}, 32'd0);
    reset = 1'b0;
    sens_lat_cfg = 0;
    repeat (80) @(negedge clk);
    check_eq("late_done_ignored", txc_q.size(), 32'd0);
    check_eq("late_done_idle", 32'(busy), 32'd0);
    do_oneshot(8'h02, 8'h0B);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/sensor_cmd_scheduler.md
Name: sensor_cmd_scheduler

Overview:
Sequences the sensor datapath from UART traffic. It assembles received command/address byte pairs and validates the command codes. It launches reads on the shared DHT11 reader, formats two-byte responses for the UART transmitter, and runs periodic continuous temperature/humidity reads. One-shot host requests are arbitrated against periodic ticks so that only one sensor transaction is outstanding at a time.

Parameters:
ADDR_W, 5, sensor address width; addresses 0..NUM_SENSORS-1 are valid.
NUM_SENSORS, 32, number of addressable sensors.
PERIOD_CYCLES, 50_000_000, clocks between continuous-mode reads (1 s at 50 MHz).
BYTE_TIMEOUT, 5_000_000, maximum clocks between the command byte and the address byte.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe, rx_data valid
rx_data  in  8  received UART byte
sens_start  out  1  one-cycle pulse, launches a sensor read
sens_addr  out  ADDR_W  sensor to read, stable from sens_start until sens_done
sens_done  in  1  one-cycle pulse, read finished
sens_err  in  1  valid with sens_done; sensor fault/timeout
sens_temp  in  8  integer temperature, valid with sens_done
sens_hum  in  8  integer humidity, valid with sens_done
tx_start  out  1  one-cycle pulse, send tx_code then tx_data
tx_code  out  8  response code
tx_data  out  8  response payload
tx_busy  in  1  transmitter busy; rises the cycle after tx_start
cont_temp_on  out  1  continuous temperature active
cont_hum_on  out  1  continuous humidity active
cmd_drop  out  1  one-cycle pulse, a completed pair was discarded
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: every output is 0. Reset also clears the pair assembler, pending slot, period counter, tick_pending and alt toggle. Reset mid-transaction abandons it; a later sens_done or tx_busy is ignored until the FSM is back in IDLE.
- Pair assembler runs independently of the FSM. The first rx byte is the command and the second is the address.
  - If BYTE_TIMEOUT clocks elapse after the command byte, the half-pair is discarded silently.
  - A completed pair loads a one-entry pending slot. If the slot is full, the new pair is dropped and cmd_drop pulses in the same cycle.
- Command codes: 0x00 humidity read, 0x01 sensor status, 0x02 temperature read, 0x03 continuous temperature on, 0x04 continuous humidity on, 0x05 continuous temperature off, 0x06 continuous humidity off.
- Response codes:
  - 0x08 humidity, 0x09 temperature, 0x07 sensor OK (data 0x00).
  - 0x0D continuous temperature, 0x0E continuous humidity.
  - 0x0A temperature continuous off, 0x0B humidity continuous off (data 0x00).
  - 0x1F sensor fault (data = address).
  - 0xFF invalid command (data = command byte).
  - 0xFE invalid address (data = address byte).
- FSM states: IDLE, DECODE, ISSUE, WAIT_SENS, SEND, SEND_HOLD.
  - IDLE: pending slot full -> DECODE and the slot is consumed. Otherwise tick_pending -> ISSUE for the continuous type selected by alt. The pending slot has priority over a tick.
  - DECODE, command > 0x06: SEND with 0xFF.
  - DECODE, address >= NUM_SENSORS: SEND with 0xFE. The address check applies to every command except 0x05/0x06.
  - DECODE, 0x05/0x06: clear the flag, then SEND with 0x0A/0x0B. This applies even if the flag was already clear.
  - DECODE, 0x03/0x04: set the flag, latch the per-type address (re-activation overwrites it), then ISSUE for an immediate first read.
  - DECODE, otherwise: ISSUE.
  - ISSUE: drive sens_addr, pulse sens_start, go to WAIT_SENS.
  - WAIT_SENS on sens_done:
    - sens_err=1 -> 0x1F.
    - Otherwise, by command: 0x00 -> 0x08/hum, 0x02 -> 0x09/temp, 0x01 -> 0x07, continuous -> 0x0D/temp or 0x0E/hum.
    - Then SEND.
  - SEND: wait for tx_busy=0, pulse tx_start, go to SEND_HOLD. tx_code/tx_data are stable from tx_start until the next tx_start.
  - SEND_HOLD: tx_busy is ignored in the first cycle. Then wait for tx_busy=0 and return to IDLE.
- Period counter:
  - Counts 0..PERIOD_CYCLES-1 while either flag is set and wraps to 0. The wrap sets tick_pending.
  - The counter is held at 0 while both flags are clear.
  - tick_pending clears when serviced or when both flags clear. Multiple wraps before service collapse into one tick.
- Alternation:
  - Both flags set: each serviced tick reads the type given by alt, then alt toggles. alt starts at temperature.
  - One flag set: always that type.
  - A flag cleared while its read is in flight: the read completes and is reported.

Test Plan:
- Bytes 0x02,0x03, sensor returns temp=25 with err=0 -> sens_start with sens_addr=3, then tx_start with code 0x09, data 0x19.
- Bytes 0x07,0x00 -> tx 0xFF/0x07 and no sens_start. Bytes 0x01,0x20 -> tx 0xFE/0x20.
- Bytes 0x01,0x05, sensor err=1 -> tx 0x1F/0x05. Command byte 0x02 followed by no byte for BYTE_TIMEOUT -> nothing sent; the next pair decodes normally.
- With PERIOD_CYCLES=100: 0x03,0x01 then 0x04,0x02 -> immediate 0x0D and 0x0E responses; then reads alternate temp@1 and hum@2 every 100 clocks. 0x05,0x00 -> 0x0A/0x00, after which only humidity reads continue.
- Three pairs back-to-back while a read is in flight -> the first is held pending, the second... cmd_drop pulses once for the pair arriving while the slot is full; the pending pair is served before a simultaneous tick.
- Reset asserted during WAIT_SENS -> all outputs 0, flags clear, a late sens_done produces no tx_start.
